// File: rtl/weight_fetch_b1.sv
// Block-1 weight fetch/unpack: loads the binary-weight ROM into a local buffer on start, then
// streams one KERNEL_SIZE-bit kernel per output channel. Optional macro: WFETCH_CACHE_EN.
module weight_fetch_b1 #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DATA_DEPTH  = 2,
  parameter int unsigned KERNEL_SIZE = 7,
  parameter int unsigned OUT_CH      = 8,
  parameter int unsigned CH_WIDTH    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rom_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [KERNEL_SIZE-1:0] w_data,
  output logic [CH_WIDTH-1:0]    w_ch,
  output logic                   w_last
);

  localparam int unsigned BufWidth = DATA_WIDTH * DATA_DEPTH;
  localparam logic [CH_WIDTH-1:0]   LastCh   = CH_WIDTH'(OUT_CH - 1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DATA_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StStream} state_e;

  state_e                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rom_en_q, rom_en_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic                    w_valid_q, w_valid_d;
  logic [KERNEL_SIZE-1:0]  w_data_q, w_data_d;
  logic [CH_WIDTH-1:0]     w_ch_q, w_ch_d;
  logic                    w_last_q, w_last_d;
  logic [BufWidth-1:0]     buf_q, buf_d;
  // Read return tracking: ROM data arrives one cycle after each enabled address.
  logic                    rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
  logic                    cache_hit;
  logic                    fetch_done;
  logic [CH_WIDTH-1:0]     next_ch;

  function automatic logic [KERNEL_SIZE-1:0] kernel_of(input logic [BufWidth-1:0] b,
                                                       input logic [CH_WIDTH-1:0] c);
    kernel_of = '0;
    for (int i = 0; i < int'(OUT_CH); i++) begin
      if (c == CH_WIDTH'(i)) kernel_of = b[i*KERNEL_SIZE +: KERNEL_SIZE];
    end
  endfunction

`ifdef WFETCH_CACHE_EN
  logic loaded_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded_q <= 1'b0;
    end else if (fetch_done) begin
      loaded_q <= 1'b1;
    end
  end

  assign cache_hit = loaded_q;
`else
  assign cache_hit = 1'b0;
`endif

  assign next_ch = CH_WIDTH'(w_ch_q + 1'b1);

  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < int'(DATA_DEPTH); k++) begin
      if (rd_pend_q && rd_idx_q == ADDR_WIDTH'(k)) buf_d[k*DATA_WIDTH +: DATA_WIDTH] = rom_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    w_ch_d     = w_ch_q;
    w_last_d   = w_last_q;
    rd_pend_d  = rom_en_q;
    rd_idx_d   = rom_addr_q;
    fetch_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          if (cache_hit) begin
            state_d   = StStream;
            w_valid_d = 1'b1;
            w_ch_d    = '0;
            w_data_d  = kernel_of(buf_d, '0);
            w_last_d  = (LastCh == '0);
          end else begin
            state_d    = StFetch;
            rom_en_d   = 1'b1;
            rom_addr_d = '0;
          end
        end
      end
      StFetch: begin
        if (rom_addr_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          rom_en_d   = 1'b1;
          rom_addr_d = rom_addr_q + 1'b1;
        end
      end
      StDrain: begin
        // Last word lands in buf_d this cycle, so kernel 0 is taken from it directly.
        state_d    = StStream;
        fetch_done = 1'b1;
        w_valid_d  = 1'b1;
        w_ch_d     = '0;
        w_data_d   = kernel_of(buf_d, '0);
        w_last_d   = (LastCh == '0);
      end
      StStream: begin
        if (w_valid_q && w_ready) begin
          if (w_last_q) begin
            state_d   = StIdle;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            w_ch_d   = next_ch;
            w_data_d = kernel_of(buf_d, next_ch);
            w_last_d = (next_ch == LastCh);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_ch_q     <= '0;
      w_last_q   <= 1'b0;
      buf_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      w_ch_q     <= w_ch_d;
      w_last_q   <= w_last_d;
      buf_q      <= buf_d;
      rd_pend_q  <= rd_pend_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign w_valid  = w_valid_q;
  assign w_data   = w_data_q;
  assign w_ch     = w_ch_q;
  assign w_last   = w_last_q;

endmodule

// File: tb/tb_weight_fetch_b1.sv
// Self-checking bench for weight_fetch_b1: ROM model plus a kernel scoreboard queue.
module tb_weight_fetch_b1;

`ifdef WFETCH_CACHE_EN
  localparam bit Cache = 1'b1;
`else
  localparam bit Cache = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, w_ready;
  logic        busy, done, rom_en, w_valid, w_last;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [6:0]  w_data;
  logic [2:0]  w_ch;
  logic [31:0] mem [2];

  typedef struct packed {
    logic [2:0] ch;
    logic [6:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr[0]];

  weight_fetch_b1 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_ch     (w_ch),
    .w_last   (w_last)
  );

  task automatic push_kernels();
    logic [63:0] b;
    exp_t e;
    b = {mem[1], mem[0]};
    for (int c = 0; c < 8; c++) begin
      e.ch   = 3'(c);
      e.data = b[c*7 +: 7];
      e.last = (c == 7);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, rom_en, w_valid, w_last} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, rom_en, w_valid, w_last});
    end
    tests++;
    if ({rom_addr, w_ch, w_data} !== 18'b0) begin
      fails++; $display("FAIL reset_data: got %h expected 0", {rom_addr, w_ch, w_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    push_kernels();
    w_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk); start = 1'b0;
      tests++;
      if (rom_en !== (cyc == 1 || cyc == 2)) begin
        fails++; $display("FAIL basic_rom_en cyc%0d: got %b expected %b", cyc, rom_en, cyc <= 2);
      end
      if (cyc <= 2) begin
        tests++;
        if (rom_addr !== 8'(cyc - 1)) begin
          fails++; $display("FAIL basic_rom_addr cyc%0d: got %0d expected %0d", cyc, rom_addr, cyc - 1);
        end
      end
      tests++;
      if (w_valid !== (cyc >= 4 && cyc <= 11)) begin
        fails++; $display("FAIL basic_w_valid cyc%0d: got %b", cyc, w_valid);
      end
      tests++;
      if (busy !== (cyc <= 11) || done !== (cyc == 12)) begin
        fails++; $display("FAIL basic_busy_done cyc%0d: got busy=%b done=%b", cyc, busy, done);
      end
      if (w_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL basic_extra_kernel: got ch%0d expected none", w_ch);
        end else begin
          if ({w_ch, w_data, w_last} !== sb[0]) begin
            fails++; $display("FAIL basic_kernel: got %h expected %h", {w_ch, w_data, w_last}, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL basic_missing: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_stall();
    int ndone = 0;
    exp_t held = '0;
    bit stalled = 1'b0;
    push_kernels();
    w_ready = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (done) begin
        ndone++;
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL stall_early_done: got %0d left expected 0", sb.size()); end
      end
      if (w_valid && stalled) begin
        tests++;
        if ({w_ch, w_data, w_last} !== held) begin
          fails++; $display("FAIL stall_hold: got %h expected %h", {w_ch, w_data, w_last}, held);
        end
      end
      w_ready = (cyc % 3 == 1);
      stalled = 1'b0;
      if (w_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL stall_extra_kernel: got ch%0d expected none", w_ch);
        end else begin
          if ({w_ch, w_data, w_last} !== sb[0]) begin
            fails++; $display("FAIL stall_kernel: got %h expected %h", {w_ch, w_data, w_last}, sb[0]);
          end
          if (w_ready) void'(sb.pop_front());
          else begin stalled = 1'b1; held = sb[0]; end
        end
      end
    end
    tests++;
    if (ndone != 1 || sb.size() != 0) begin
      fails++; $display("FAIL stall_done: got done=%0d left=%0d expected 1/0", ndone, sb.size());
    end
    w_ready = 1'b1;
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    push_kernels();
    w_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (done) ndone++;
      if (cyc > 3) begin
        tests++;
        if (rom_en !== 1'b0) begin fails++; $display("FAIL busy_rom_en cyc%0d: got 1 expected 0", cyc); end
      end
      if (w_valid) begin
        if (w_ch == 3'd3) start = 1'b1;
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL busy_extra_kernel: got ch%0d expected none", w_ch);
        end else begin
          if ({w_ch, w_data, w_last} !== sb[0]) begin
            fails++; $display("FAIL busy_kernel: got %h expected %h", {w_ch, w_data, w_last}, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
    end
    tests++;
    if (ndone != 1 || sb.size() != 0) begin
      fails++; $display("FAIL busy_done: got done=%0d left=%0d expected 1/0", ndone, sb.size());
    end
  endtask

  task automatic test_start_on_done();
    int ndone = 0;
    push_kernels();
    w_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin start = 1'b1; push_kernels(); end
      end
      if (w_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_extra_kernel: got ch%0d expected none", w_ch);
        end else begin
          if ({w_ch, w_data, w_last} !== sb[0]) begin
            fails++; $display("FAIL b2b_kernel: got %h expected %h", {w_ch, w_data, w_last}, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
    end
    tests++;
    if (ndone != 2 || sb.size() != 0) begin
      fails++; $display("FAIL b2b_done: got done=%0d left=%0d expected 2/0", ndone, sb.size());
    end
  endtask

  task automatic test_rst_mid();
    int ndone = 0;
    bit hit = 1'b0;
    w_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 20 && !hit; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (w_valid && w_ch == 3'd5) begin
        hit = 1'b1;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, rom_en, w_valid, w_last, rom_addr, w_ch, w_data} !== 23'b0) begin
          fails++; $display("FAIL rst_mid_outputs: got %h expected 0",
                            {busy, done, rom_en, w_valid, w_last, rom_addr, w_ch, w_data});
        end
      end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL rst_mid_reach_ch5: got timeout expected ch5"); end
    @(negedge clk); rst = 1'b0;
    sb.delete();
    push_kernels();
    @(negedge clk); start = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (done) ndone++;
      if (cyc == 1) begin
        tests++;
        if (rom_en !== 1'b1) begin fails++; $display("FAIL rst_refetch: got rom_en=%b expected 1", rom_en); end
      end
      if (w_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL rst_extra_kernel: got ch%0d expected none", w_ch);
        end else begin
          if ({w_ch, w_data, w_last} !== sb[0]) begin
            fails++; $display("FAIL rst_kernel: got %h expected %h", {w_ch, w_data, w_last}, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
    end
    tests++;
    if (ndone != 1 || sb.size() != 0) begin
      fails++; $display("FAIL rst_done: got done=%0d left=%0d expected 1/0", ndone, sb.size());
    end
  endtask

  task automatic test_second_run();
    int first = Cache ? 1 : 4;
    push_kernels();
    w_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk); start = 1'b0;
      tests++;
      if (rom_en !== (!Cache && cyc <= 2)) begin
        fails++; $display("FAIL rerun_rom_en cyc%0d: got %b", cyc, rom_en);
      end
      tests++;
      if (w_valid !== (cyc >= first && cyc < first + 8) || done !== (cyc == first + 8)) begin
        fails++; $display("FAIL rerun_timing cyc%0d: got valid=%b done=%b", cyc, w_valid, done);
      end
      if (w_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL rerun_extra_kernel: got ch%0d expected none", w_ch);
        end else begin
          if ({w_ch, w_data, w_last} !== sb[0]) begin
            fails++; $display("FAIL rerun_kernel: got %h expected %h", {w_ch, w_data, w_last}, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL rerun_missing: got %0d left expected 0", sb.size()); end
  endtask

  initial begin
    mem[0] = 32'hA5A5_1234;
    mem[1] = 32'h00C3_F0F0;
    test_reset();
    test_basic();
    test_stall();
    test_start_while_busy();
    test_start_on_done();
    test_rst_mid();
    test_second_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_fetch_b1.md
Name: weight_fetch_b1

Overview:
Block-1 weight fetch/unpack controller, directly downstream of the block-1 binary-weight ROM.
- On a start pulse, reads every ROM word (1-cycle synchronous ROM latency) into a packed local buffer.
- Streams one KERNEL_SIZE-bit binary kernel per output channel to the block-1 XNOR/popcount conv engine over a valid/ready handshake.
- Pulses done after the last channel is accepted.

Parameters:
ADDR_WIDTH, 8, ROM address width
DATA_WIDTH, 32, ROM word width
DATA_DEPTH, 2, number of ROM words to fetch
KERNEL_SIZE, 7, taps per kernel (bits per w_data)
OUT_CH, 8, output channels streamed
CH_WIDTH, 3, width of w_ch (>= clog2(OUT_CH))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle load-and-stream request
busy  output  1  high from start acceptance until done
done  output  1  single-cycle pulse after last kernel accepted
rom_en  output  1  ROM read enable
rom_addr  output  ADDR_WIDTH  ROM word address
rom_data  input  DATA_WIDTH  ROM read data, valid 1 cycle after rom_en
w_valid  output  1  kernel valid
w_ready  input  1  conv engine accepts kernel
w_data  output  KERNEL_SIZE  binary kernel for channel w_ch
w_ch  output  CH_WIDTH  output-channel index of w_data
w_last  output  1  high with w_valid when w_ch == OUT_CH-1

Behaviour:
- Constraint: OUT_CH*KERNEL_SIZE <= DATA_WIDTH*DATA_DEPTH. Default is 56 <= 64; upper 8 bits unused.
- Reset (async, rst=1): state IDLE; busy, done, rom_en, w_valid, w_last = 0; rom_addr, w_ch, w_data, counters, buffer = 0.
- FSM states: IDLE, FETCH, DRAIN, STREAM. All outputs are registered.
- IDLE: start=1 at edge T -> FETCH; busy=1 from T+1.
- FETCH: rom_en=1 for exactly DATA_DEPTH cycles (T+1 .. T+DATA_DEPTH), rom_addr = 0,1,..,DATA_DEPTH-1. After the last address -> DRAIN.
- Capture: rom_data sampled one cycle after each rom_en cycle; word k stored at buffer[k*DATA_WIDTH +: DATA_WIDTH] (word 0 at LSBs).
- DRAIN: one cycle, rom_en=0, last word captured -> STREAM.
- STREAM: w_valid=1 first at T+DATA_DEPTH+2 with w_ch=0. Kernel c = buffer[c*KERNEL_SIZE +: KERNEL_SIZE], bit 0 = tap 0.
  - Handshake fires when w_valid & w_ready. On a handshake, w_ch increments and w_data updates on the next edge.
  - w_data and w_ch hold stable while w_valid & !w_ready. w_ready is ignored when w_valid=0.
- Last handshake (w_ch==OUT_CH-1): next cycle w_valid=0, w_last=0, busy=0, done=1 for one cycle, state IDLE.
- start while busy: ignored, no restart.
- start in the same cycle as done: accepted (state is already IDLE); done still pulses.
- Back-to-back: with w_ready tied high, one kernel per cycle, OUT_CH consecutive valid cycles.
- rst mid-operation: immediate return to IDLE with reset values. Partially streamed channels are abandoned. The buffer is cleared.

Optional Feature:
Macro: WFETCH_CACHE_EN
- Defined: a wbuf_loaded flag is set after the first complete FETCH/DRAIN and cleared only by rst. A start accepted with wbuf_loaded=1 skips FETCH/DRAIN and goes IDLE -> STREAM; w_valid is first high at T+1 and rom_en stays 0.
- Not defined: every start performs the full ROM fetch; no flag exists.

Test Plan:
1. ROM model word0=32'hA5A5_1234, word1=32'h00C3_F0F0, w_ready=1, start at T -> rom_en high T+1..T+2 with addr 0,1. w_valid T+4..T+11. w_data ch0=7'h34, ch1=7'h24, ch4=7'h0A (crosses word boundary), ch7=7'h61. w_last only at ch7. done=1 at T+12, busy=0 at T+12.
2. Same ROM, w_ready toggled 1,0,0,1,... -> w_data/w_ch stable through stalls, all 8 kernels delivered in order exactly once, done after the 8th handshake.
3. Second start pulse issued while busy (e.g. during STREAM at ch3) -> no change in sequence, single done, rom_en not reasserted.
4. rst asserted asynchronously mid-STREAM (at ch5) -> all outputs 0 within the same cycle. A new start re-fetches (without WFETCH_CACHE_EN) and streams from ch0 with correct values.
5. start coincident with the done cycle -> second sequence runs immediately, identical kernels, second done pulse.
6. WFETCH_CACHE_EN defined, two runs -> first run as in test 1. Second run: rom_en never asserted, w_valid at T+1, same 8 kernels.
